data_cal_arb: RTL and testbench
===============================

# data_cal_arb

Round-robin scheduler that shares one `data_cal` nibble-sum engine between `NREQ` requesters. Each requester submits a 16-bit word and a mask of the sums it wants. The block then:
- grants one request at a time;
- drives the engine through a load cycle and one issue cycle per requested `sel`;
- returns each result on a single response channel with requester ID and backpressure.

It sits between the request sources and the engine instance; no requester drives the engine directly.

## Interface
Parameters:
- `NREQ`, 2, number of requesters (2..4)
- `IDW`, `$clog2(NREQ)`, requester ID width

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  request valid, one bit per requester
- `req_ready`  out  NREQ  one-hot accept pulse
- `req_d`  in  NREQ*16  data words, requester i at [16i+15:16i]
- `req_mask`  in  NREQ*3  mask per requester; bit k-1 requests `sel`=k
- `eng_d`  out  16  engine data
- `eng_sel`  out  2  engine select
- `eng_out`  in  5  engine result
- `eng_validout`  in  1  engine result valid
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_id`  out  IDW  granted requester
- `rsp_sel`  out  2  `sel` this result belongs to (0 for an empty mask)
- `rsp_data`  out  5  result
- `rsp_last`  out  1  final response of this request

## Operation
- Engine contract:
  - `sel`=0 loads `d`; `validout`=0 the following cycle.
  - `sel`=1/2/3 returns `d[3:0]` plus `d[7:4]`, `d[11:8]` or `d[15:12]` respectively, registered, with `validout`=1 exactly one cycle after issue.
- States: IDLE, LOAD, ISSUE, WAIT, RESP.
- IDLE:
  - `eng_sel`=0, `eng_d`=0.
  - If any `req_valid` is set, the round-robin winner gets `req_ready`=1 in that cycle. `req_ready` is combinational from state and `req_valid`.
  - On grant, latch d, mask (into a `pending` register) and ID; go to LOAD.
- Empty mask (`pending`==0 at grant): skip the engine and go to RESP with `rsp_sel`=0, `rsp_data`=0, `rsp_last`=1.
- LOAD: `eng_sel`=0, `eng_d`=latched word; go to ISSUE.
- ISSUE:
  - `eng_sel`=k, where k is the lowest set bit of `pending` plus 1; `eng_d` held.
  - Go to WAIT.
- WAIT:
  - When `eng_validout`=1, capture `eng_out` into `rsp_data` and go to RESP.
  - `eng_validout` must arrive in this cycle. If it does not, stay in WAIT; there is no timeout.
- RESP:
  - `rsp_valid`=1; all `rsp_*` fields stay stable until `rsp_ready`=1.
  - On the handshake, clear bit k-1 of `pending`.
  - If bits remain, go to ISSUE (no reload needed; the engine keeps d). Otherwise go to IDLE and advance the RR pointer.
- `rsp_last` = 1 when `pending` has exactly one bit set (or the mask was empty).
- Round-robin:
  - The pointer holds the ID of the last grant; search starts at pointer+1 and wraps modulo NREQ.
  - The pointer updates only on grant.
- Requests that arrive mid-operation wait. `req_valid` may drop before grant; the requester is simply not served.

## Timing
- Reset values: state IDLE, RR pointer NREQ-1 (so requester 0 wins first), `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sel`=0, `rsp_data`=0, `rsp_last`=0, `eng_sel`=0, `eng_d`=0, `pending`=0.
- Cycle numbering: grant at cycle 0, LOAD at 1, ISSUE at 2, WAIT at 3, first `rsp_valid` at 4.
- Each further result costs 3 cycles (ISSUE, WAIT, RESP) when `rsp_ready` is held high.
- Full mask with `rsp_ready` high: grant to last-response handshake = 10 cycles. The next grant is possible 1 cycle later.
- Reset mid-operation: the in-flight request is dropped with no response, and all outputs return to reset values the next cycle. The engine is reset by the same event at top level.
- Simultaneous `req_valid` from all requesters: exactly one `req_ready` bit is set, per RR order.

## Structure
- `data_cal_pkg`: constants D_W=16, OUT_W=5, SEL_W=2, SEL_LOAD=2'd0, plus the state enum.
- Sub-module `rr_arb` (NREQ-wide round-robin picker: inputs request vector, pointer and enable; output one-hot grant and ID).
- Target size: ~200 RTL lines.

## Test plan
- Single request: requester 0, d=16'h1234, mask=3'b111. Required responses in order: (sel1, 7), (sel2, 6), (sel3, 5); `rsp_last` set only on the third; first `rsp_valid` at cycle 4.
- Both requesters valid at once: req0 d=16'h1234 mask=3'b010, req1 d=16'h2345 mask=3'b101. Required order: id0 (sel2, 6), then id1 (sel1, 9), then id1 (sel3, 7).
- Backpressure: hold `rsp_ready`=0 for 5 cycles during the first response. Required: `rsp_*` stable throughout, `eng_sel` held at 0 while stalled in RESP, no lost result.
- Empty mask: mask=3'b000 from requester 1. Required: one response with id1, sel0, data0, last=1; engine `eng_sel` never leaves 0.
- Fairness: both requesters continuously valid for 6 requests. Required: grants alternate 0,1,0,1,0,1.
- Reset at WAIT: assert `rst` one cycle. Required: no response for the dropped request; next grant goes to requester 0 with a correct result.

Source files
------------

// File: rtl/data_cal_pkg.sv
// Shared constants, FSM state encoding and mask helpers for the data_cal arbiter.
//   D_W      engine data word width
//   OUT_W    engine result width
//   SEL_W    engine select width
//   MASK_W   per-request sum mask width (bit k-1 requests sel=k)
package data_cal_pkg;

  localparam int unsigned D_W    = 16;
  localparam int unsigned OUT_W  = 5;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned MASK_W = 3;

  localparam logic [SEL_W-1:0] SEL_LOAD = 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Engine select for the lowest outstanding mask bit (0 when nothing is pending).
  function automatic logic [SEL_W-1:0] first_sel(input logic [MASK_W-1:0] p);
    if (p[0])      return 2'd1;
    else if (p[1]) return 2'd2;
    else if (p[2]) return 2'd3;
    else           return SEL_LOAD;
  endfunction

  // True when exactly one mask bit is set.
  function automatic logic is_single(input logic [MASK_W-1:0] p);
    return (p != '0) && ((p & (p - MASK_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/data_cal_arb_rr_arb.sv
// Round-robin picker: searches upward from ptr+1 (wrapping) for the first
// active request.
//   req      request vector
//   ptr      ID of the previous grant
//   en       allow a grant this cycle
//   gnt      one-hot grant
//   gnt_id   binary ID of the grant
//   gnt_any  a grant was issued
module rr_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_any
);

  // Priority scan over rotation offsets 1..NREQ; the first hit wins.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int o = 1; o <= int'(NREQ); o++) begin
      idx = (int'(ptr) + o) % int'(NREQ);
      for (int j = 0; j < int'(NREQ); j++) begin
        if (en && !gnt_any && (j == idx) && req[j]) begin
          gnt[j]  = 1'b1;
          gnt_id  = IDW'(j);
          gnt_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/data_cal_arb.sv
// Round-robin scheduler sharing one data_cal nibble-sum engine among NREQ
// requesters. Each granted request is loaded once, then issued once per
// requested select; each result is returned on a single backpressured channel.
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/ready          per-requester handshake (ready is a one-hot pulse)
//   req_d, req_mask          per-requester data word and select mask
//   eng_d, eng_sel           engine command
//   eng_out, eng_validout    engine result
//   rsp_valid/ready          response handshake
//   rsp_id/sel/data/last     response payload
module data_cal_arb
  import data_cal_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*D_W-1:0]    req_d,
  input  logic [NREQ*MASK_W-1:0] req_mask,
  output logic [D_W-1:0]         eng_d,
  output logic [SEL_W-1:0]       eng_sel,
  input  logic [OUT_W-1:0]       eng_out,
  input  logic                   eng_validout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [SEL_W-1:0]       rsp_sel,
  output logic [OUT_W-1:0]       rsp_data,
  output logic                   rsp_last
);

  state_t             state_q, state_n;
  logic [IDW-1:0]     ptr_q, ptr_n;
  logic [MASK_W-1:0]  pending_q, pending_n, pend_left;
  logic [D_W-1:0]     eng_d_n;
  logic [SEL_W-1:0]   eng_sel_n;
  logic               rsp_valid_n, rsp_last_n;
  logic [IDW-1:0]     rsp_id_n;
  logic [SEL_W-1:0]   rsp_sel_n;
  logic [OUT_W-1:0]   rsp_data_n;

  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_any;
  logic [D_W-1:0]     gnt_d;
  logic [MASK_W-1:0]  gnt_mask;

  // Grants are only offered from IDLE and never while reset is asserted.
  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_rr_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      ((state_q == ST_IDLE) && !rst),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  // One-hot mux of the granted requester's word and mask.
  always_comb begin
    gnt_d    = '0;
    gnt_mask = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt[i]) begin
        gnt_d    = gnt_d    | req_d[i*D_W +: D_W];
        gnt_mask = gnt_mask | req_mask[i*MASK_W +: MASK_W];
      end
    end
  end

  // Next-state and next-output logic; eng_sel is non-zero only during ISSUE.
  always_comb begin
    state_n     = state_q;
    ptr_n       = ptr_q;
    pending_n   = pending_q;
    eng_d_n     = eng_d;
    eng_sel_n   = SEL_LOAD;
    rsp_valid_n = rsp_valid;
    rsp_id_n    = rsp_id;
    rsp_sel_n   = rsp_sel;
    rsp_data_n  = rsp_data;
    rsp_last_n  = rsp_last;
    pend_left   = pending_q & (pending_q - MASK_W'(1));

    case (state_q)
      ST_IDLE: begin
        eng_d_n = '0;
        if (gnt_any) begin
          ptr_n     = gnt_id;
          rsp_id_n  = gnt_id;
          pending_n = gnt_mask;
          if (gnt_mask == '0) begin
            // Nothing to compute: answer immediately without touching the engine.
            rsp_valid_n = 1'b1;
            rsp_sel_n   = SEL_LOAD;
            rsp_data_n  = '0;
            rsp_last_n  = 1'b1;
            state_n     = ST_RESP;
          end else begin
            eng_d_n = gnt_d;
            state_n = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        eng_sel_n = first_sel(pending_q);
        state_n   = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_validout) begin
          rsp_valid_n = 1'b1;
          rsp_sel_n   = first_sel(pending_q);
          rsp_data_n  = eng_out;
          rsp_last_n  = is_single(pending_q);
          state_n     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          pending_n   = pend_left;
          if (pend_left != '0) begin
            // Engine still holds the word, so go straight to the next issue.
            eng_sel_n = first_sel(pend_left);
            state_n   = ST_ISSUE;
          end else begin
            eng_d_n = '0;
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDW'(NREQ - 1);
      pending_q <= '0;
      eng_d     <= '0;
      eng_sel   <= SEL_LOAD;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sel   <= '0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      state_q   <= state_n;
      ptr_q     <= ptr_n;
      pending_q <= pending_n;
      eng_d     <= eng_d_n;
      eng_sel   <= eng_sel_n;
      rsp_valid <= rsp_valid_n;
      rsp_id    <= rsp_id_n;
      rsp_sel   <= rsp_sel_n;
      rsp_data  <= rsp_data_n;
      rsp_last  <= rsp_last_n;
    end
  end

endmodule

// File: tb/tb_data_cal_arb.sv
// Self-checking bench for data_cal_arb with a behavioural data_cal engine.
module tb_data_cal_arb;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*16-1:0] req_d;
  logic [NREQ*3-1:0] req_mask;
  logic [15:0]       eng_d;
  logic [1:0]        eng_sel;
  logic [4:0]        eng_out;
  logic              eng_validout;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [1:0]        rsp_sel;
  logic [4:0]        rsp_data;
  logic              rsp_last;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  data_cal_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_d        (req_d),
    .req_mask     (req_mask),
    .eng_d        (eng_d),
    .eng_sel      (eng_sel),
    .eng_out      (eng_out),
    .eng_validout (eng_validout),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sel      (rsp_sel),
    .rsp_data     (rsp_data),
    .rsp_last     (rsp_last)
  );

  // Behavioural engine: sel=0 loads d, sel=k returns nibble0 + nibble k one cycle later.
  logic [15:0] eng_dq;
  always @(posedge clk) begin
    if (rst) begin
      eng_dq       <= '0;
      eng_out      <= '0;
      eng_validout <= 1'b0;
    end else if (eng_sel == 2'd0) begin
      eng_dq       <= eng_d;
      eng_validout <= 1'b0;
    end else begin
      eng_validout <= 1'b1;
      case (eng_sel)
        2'd1:    eng_out <= {1'b0, eng_dq[3:0]} + {1'b0, eng_dq[7:4]};
        2'd2:    eng_out <= {1'b0, eng_dq[3:0]} + {1'b0, eng_dq[11:8]};
        default: eng_out <= {1'b0, eng_dq[3:0]} + {1'b0, eng_dq[15:12]};
      endcase
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && rsp_valid && rsp_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    int              id;
    logic [15:0]     d;
    logic [2:0]      mask;
    int              n;
    logic [2:0][1:0] sel;
    logic [2:0][4:0] data;
  } vec_t;

  function automatic vec_t mk(input int id, input logic [15:0] d, input logic [2:0] m,
                              input int n, input int s0, input int d0, input int s1,
                              input int d1, input int s2, input int d2);
    vec_t v;
    v.id      = id;
    v.d       = d;
    v.mask    = m;
    v.n       = n;
    v.sel[0]  = 2'(s0);
    v.data[0] = 5'(d0);
    v.sel[1]  = 2'(s1);
    v.data[1] = 5'(d1);
    v.sel[2]  = 2'(s2);
    v.data[2] = 5'(d2);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int id, input logic [15:0] d, input logic [2:0] m);
    req_valid[id]       = 1'b1;
    req_d[id*16 +: 16]  = d;
    req_mask[id*3 +: 3] = m;
  endtask

  // Waits for requester id to be granted (grant cycle number in gcyc), then drops its valid.
  task automatic wait_grant(input int id, output int gcyc);
    int t;
    t    = 0;
    gcyc = -1;
    while (t < 100) begin
      #1;
      if (req_ready != '0) begin
        gcyc = cyc;
        break;
      end
      @(negedge clk);
      t++;
    end
    check($sformatf("grant_onehot_req%0d", id), int'(req_ready), 1 << id);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
  endtask

  // Returns the next presented response (sampled at negedge) and whether eng_sel was seen non-zero.
  task automatic get_rsp(output int id, output int sel, output int data, output int last,
                         output int rcyc, output int eng_nz);
    int t;
    t = 0; rcyc = -1; eng_nz = 0; id = -1; sel = -1; data = -1; last = -1;
    while (t < 100) begin
      @(negedge clk);
      if (eng_sel != 2'd0) eng_nz = 1;
      if (rsp_valid) begin
        id   = int'(rsp_id);
        sel  = int'(rsp_sel);
        data = int'(rsp_data);
        last = int'(rsp_last);
        rcyc = cyc;
        break;
      end
      t++;
    end
    check("rsp_arrives", int'(rcyc >= 0), 1);
  endtask

  task automatic expect_rsp(input string name, input int eid, input int esel, input int edata,
                            input int elast);
    int id, sel, data, last, r, nz;
    get_rsp(id, sel, data, last, r, nz);
    check({name, "_id"}, id, eid);
    check({name, "_sel"}, sel, esel);
    check({name, "_data"}, data, edata);
    check({name, "_last"}, last, elast);
  endtask

  initial begin
    vec_t vecs[6];
    int   g, r, id, sel, data, last, nz, prev, h0, ngr, exp_cyc;

    rst       = 1'b1;
    req_valid = '0;
    req_d     = '0;
    req_mask  = '0;
    rsp_ready = 1'b1;

    vecs[0] = mk(0, 16'h1234, 3'b111, 3, 1, 7, 2, 6, 3, 5);
    vecs[1] = mk(1, 16'hFFFF, 3'b100, 1, 3, 30, 0, 0, 0, 0);
    vecs[2] = mk(0, 16'h0000, 3'b011, 2, 1, 0, 2, 0, 0, 0);
    vecs[3] = mk(1, 16'h8421, 3'b110, 2, 2, 5, 3, 9, 0, 0);
    vecs[4] = mk(1, 16'h1234, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    vecs[5] = mk(0, 16'hABCD, 3'b101, 2, 1, 25, 3, 23, 0, 0);

    // Reset values
    do_reset();
    #1;
    check("reset_req_ready", int'(req_ready), 0);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_id", int'(rsp_id), 0);
    check("reset_rsp_sel", int'(rsp_sel), 0);
    check("reset_rsp_data", int'(rsp_data), 0);
    check("reset_rsp_last", int'(rsp_last), 0);
    check("reset_eng_sel", int'(eng_sel), 0);
    check("reset_eng_d", int'(eng_d), 0);

    // Table of single-requester transactions with latency checks
    for (int v = 0; v < 6; v++) begin
      set_req(vecs[v].id, vecs[v].d, vecs[v].mask);
      wait_grant(vecs[v].id, g);
      prev = g;
      for (int k = 0; k < vecs[v].n; k++) begin
        get_rsp(id, sel, data, last, r, nz);
        check($sformatf("v%0d_r%0d_id", v, k), id, vecs[v].id);
        check($sformatf("v%0d_r%0d_sel", v, k), sel, int'(vecs[v].sel[k]));
        check($sformatf("v%0d_r%0d_data", v, k), data, int'(vecs[v].data[k]));
        check($sformatf("v%0d_r%0d_last", v, k), last, int'(k == vecs[v].n - 1));
        if (k == 0) exp_cyc = (vecs[v].mask == 3'b000) ? g + 1 : g + 4;
        else        exp_cyc = prev + 3;
        check($sformatf("v%0d_r%0d_cycle", v, k), r - g, exp_cyc - g);
        if (vecs[v].mask == 3'b000) check($sformatf("v%0d_eng_idle", v), nz, 0);
        prev = r;
      end
    end

    // Backpressure on the first response of a full-mask request
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    h0 = hs_cnt;
    set_req(0, 16'h1234, 3'b111);
    wait_grant(0, g);
    get_rsp(id, sel, data, last, r, nz);
    check("bp_first_sel", sel, 1);
    check("bp_first_data", data, 7);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_rsp", s),
            int'({rsp_valid, rsp_id, rsp_sel, rsp_data, rsp_last}),
            int'({1'b1, 1'b0, 2'd1, 5'd7, 1'b0}));
      check($sformatf("bp_hold%0d_eng_sel", s), int'(eng_sel), 0);
    end
    rsp_ready = 1'b1;
    expect_rsp("bp_r1", 0, 2, 6, 0);
    expect_rsp("bp_r2", 0, 3, 5, 1);
    @(negedge clk);
    check("bp_handshakes", hs_cnt - h0, 3);

    // Simultaneous requests after reset: requester 0 first
    do_reset();
    set_req(0, 16'h1234, 3'b010);
    set_req(1, 16'h2345, 3'b101);
    #1;
    check("both_first_grant", int'(req_ready), 1);
    wait_grant(0, g);
    expect_rsp("both_id0", 0, 2, 6, 1);
    wait_grant(1, g);
    expect_rsp("both_id1_a", 1, 1, 9, 0);
    expect_rsp("both_id1_b", 1, 3, 7, 1);

    // Fairness under continuous requests
    do_reset();
    set_req(0, 16'h1234, 3'b001);
    set_req(1, 16'h2345, 3'b001);
    ngr = 0;
    for (int t = 0; t < 300 && ngr < 6; t++) begin
      #1;
      if (req_ready != '0) begin
        check($sformatf("fair_grant%0d", ngr), int'(req_ready), 1 << (ngr % 2));
        ngr++;
        if (ngr == 6) begin
          @(posedge clk);
          #1;
          req_valid = '0;
        end
      end
      @(negedge clk);
    end
    check("fair_count", ngr, 6);
    repeat (10) @(negedge clk);

    // Reset while waiting on the engine
    set_req(1, 16'h1234, 3'b111);
    wait_grant(1, g);
    repeat (3) @(negedge clk);
    h0  = hs_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstw_rsp_valid", int'(rsp_valid), 0);
    check("rstw_rsp_data", int'(rsp_data), 0);
    check("rstw_eng_d", int'(eng_d), 0);
    check("rstw_eng_sel", int'(eng_sel), 0);
    check("rstw_req_ready", int'(req_ready), 0);
    repeat (10) @(negedge clk);
    check("rstw_no_rsp", hs_cnt - h0, 0);
    set_req(0, 16'h1234, 3'b010);
    set_req(1, 16'hFFFF, 3'b001);
    wait_grant(0, g);
    req_valid[1] = 1'b0;
    expect_rsp("rstw_next", 0, 2, 6, 1);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
